router_fsm_n: RTL and testbench

- Parametrised successor to the 1x3 router control FSM: one input port steering packets to N output FIFOs.
- Decodes the header address, sequences LFD/LD/LP/CPE loading, and handles FIFO-full stalls and wait-till-empty.
- New over the 1x3 FSM:
  - per-channel vector interfaces;
  - a latched one-hot destination select;
  - an invalid-address DROP_PACKET path with a saturating drop counter;
  - per-channel soft-reset abort.
- Sits between the router register block, the synchroniser, and the N FIFOs.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm_n.sv | 124 ++++++++++++
 tb/tb_router_fsm_n.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared state encoding and helpers for the parametrised router control FSM.
package router_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_DA   = 4'd0;
  localparam state_t ST_LFD  = 4'd1;
  localparam state_t ST_LD   = 4'd2;
  localparam state_t ST_LP   = 4'd3;
  localparam state_t ST_FFS  = 4'd4;
  localparam state_t ST_LAF  = 4'd5;
  localparam state_t ST_WTE  = 4'd6;
  localparam state_t ST_CPE  = 4'd7;
  localparam state_t ST_DROP = 4'd8;

  // One bit of a one-hot decode: true when the header index selects position pos.
  function automatic logic onehot_hit(input int idx, input int pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/router_fsm_n.sv
// Router control FSM for one input port feeding N output FIFOs: header decode,
// load sequencing, full/empty stalls, invalid-address drop and per-channel abort.
module router_fsm_n
  import router_pkg::*;
#(
  parameter int N      = 3,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [N-1:0]      fifo_full,
  input  logic [N-1:0]      fifo_empty,
  input  logic [N-1:0]      soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [N-1:0]      dest_sel,
  output logic [CNT_W-1:0]  drop_count
);

  state_t           state_q, state_d;
  logic [N-1:0]     dest_sel_q, dest_sel_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic [N-1:0] hdr_sel;
  logic [N-1:0] cur_sel;
  logic         addr_ok;
  logic         full;
  logic         empty;
  logic         soft_hit;

  // In DA the live header selects the channel; afterwards the latched select does.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hdr_sel = '0;
    for (int i = 0; i < N; i++) begin
      hdr_sel[i] = onehot_hit(32'(data_in), i);
    end
    addr_ok  = |hdr_sel;
    cur_sel  = (state_q == ST_DA) ? hdr_sel : dest_sel_q;
    full     = |(fifo_full  & cur_sel);
    empty    = |(fifo_empty & cur_sel);
    soft_hit = |(soft_reset & cur_sel);
  end

  always_comb begin
    state_d      = state_q;
    dest_sel_d   = dest_sel_q;
    drop_count_d = drop_count_q;

    unique case (state_q)
      ST_DA: begin
        if (pkt_valid) begin
          dest_sel_d = hdr_sel;
          if (!addr_ok)   state_d = ST_DROP;
          else if (empty) state_d = ST_LFD;
          else            state_d = ST_WTE;
        end
      end
      ST_WTE:  if (empty) state_d = ST_LFD;
      ST_LFD:  state_d = ST_LD;
      ST_LD: begin
        if (full)            state_d = ST_FFS;
        else if (!pkt_valid) state_d = ST_LP;
      end
      ST_FFS:  if (!full) state_d = ST_LAF;
      ST_LAF: begin
        if (parity_done)        state_d = ST_DA;
        else if (low_pkt_valid) state_d = ST_LP;
        else                    state_d = ST_LD;
      end
      ST_LP:   state_d = ST_CPE;
      ST_CPE:  state_d = full ? ST_FFS : ST_DA;
      ST_DROP: begin
        if (!pkt_valid) begin
          state_d = ST_DA;
          if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_DA;
    endcase

    // A timeout on the selected channel aborts the packet from any loading state.
    if (soft_hit && state_q != ST_DA && state_q != ST_DROP) state_d = ST_DA;
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_DA;
      dest_sel_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dest_sel_q   <= dest_sel_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign detect_add    = (state_q == ST_DA);
  assign lfd_state     = (state_q == ST_LFD);
  assign ld_state      = (state_q == ST_LD);
  assign laf_state     = (state_q == ST_LAF);
  assign full_state    = (state_q == ST_FFS);
  assign drop_state    = (state_q == ST_DROP);
  assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LP) || (state_q == ST_LAF);
  assign rst_int_reg   = (state_q == ST_CPE);
  assign busy          = (state_q == ST_LFD) || (state_q == ST_LP) || (state_q == ST_FFS) ||
                         (state_q == ST_LAF) || (state_q == ST_WTE) || (state_q == ST_CPE);
  assign dest_sel      = dest_sel_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n: N=3 main instance plus an N=4 instance
// where every header address is valid.
module tb_router_fsm_n;

  localparam int N      = 3;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 8;

  // Decoded output vector:
  // {detect_add, lfd, ld, laf, full, drop, write_enb_reg, rst_int_reg, busy}
  localparam logic [8:0] V_DA   = 9'b100000000;
  localparam logic [8:0] V_LFD  = 9'b010000001;
  localparam logic [8:0] V_LD   = 9'b001000100;
  localparam logic [8:0] V_LP   = 9'b000000101;
  localparam logic [8:0] V_FFS  = 9'b000010001;
  localparam logic [8:0] V_LAF  = 9'b000100101;
  localparam logic [8:0] V_WTE  = 9'b000000001;
  localparam logic [8:0] V_CPE  = 9'b000000011;
  localparam logic [8:0] V_DROP = 9'b000001000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, pkt_valid, parity_done, low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [N-1:0]      fifo_full, fifo_empty, soft_reset;
  logic              detect_add, lfd_state, ld_state, laf_state, full_state;
  logic              write_enb_reg, rst_int_reg, busy, drop_state;
  logic [N-1:0]      dest_sel;
  logic [CNT_W-1:0]  drop_count;

  logic [3:0]        fifo_full4, fifo_empty4, soft_reset4, dest_sel4;
  logic              detect_add4, lfd_state4, ld_state4, laf_state4, full_state4;
  logic              write_enb_reg4, rst_int_reg4, busy4, drop_state4;
  logic [CNT_W-1:0]  drop_count4;

  int checks = 0;
  int errors = 0;

  router_fsm_n #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
    .dest_sel(dest_sel), .drop_count(drop_count)
  );

  router_fsm_n #(.N(4), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut4 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full4), .fifo_empty(fifo_empty4), .soft_reset(soft_reset4),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add4), .lfd_state(lfd_state4), .ld_state(ld_state4),
    .laf_state(laf_state4), .full_state(full_state4), .write_enb_reg(write_enb_reg4),
    .rst_int_reg(rst_int_reg4), .busy(busy4), .drop_state(drop_state4),
    .dest_sel(dest_sel4), .drop_count(drop_count4)
  );

  function automatic logic [8:0] obs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    data_in       = '0;
    fifo_full     = '0;
    fifo_empty    = '1;
    soft_reset    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs() !== V_DA) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs(), V_DA);
    end
    checks++;
    if (dest_sel !== 3'b000 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: dest_sel %b drop_count %0d want 000 and 0", dest_sel, drop_count);
    end
  endtask

  task automatic test_basic_packet();
    logic [8:0] exp_v [6] = '{V_LFD, V_LD, V_LD, V_LP, V_CPE, V_DA};
    logic       pv    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    data_in    = 2'd1;
    fifo_empty = 3'b010;
    for (int i = 0; i < 6; i++) begin
      pkt_valid = pv[i];
      tick();
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL basic step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    checks++;
    if (dest_sel !== 3'b010) begin
      errors++;
      $display("FAIL basic_dest_sel: got %b want 010", dest_sel);
    end
    idle_inputs();
  endtask

  task automatic test_full_stall();
    logic [8:0] exp_v [9] = '{V_LFD, V_LD, V_FFS, V_FFS, V_FFS, V_LAF, V_LP, V_CPE, V_DA};
    logic       pv    [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       fl    [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       lo    [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    data_in    = 2'd0;
    fifo_empty = 3'b001;
    for (int i = 0; i < 9; i++) begin
      pkt_valid     = pv[i];
      fifo_full     = fl[i] ? 3'b001 : 3'b000;
      low_pkt_valid = lo[i];
      tick();
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL full_stall step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_laf_exits();
    // LAF with neither flag goes back to LD; with parity_done it ends the packet.
    logic [8:0] exp_v [7] = '{V_LFD, V_LD, V_FFS, V_LAF, V_LD, V_FFS, V_LAF};
    logic       fl    [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    data_in    = 2'd0;
    fifo_empty = 3'b001;
    pkt_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fifo_full = fl[i] ? 3'b001 : 3'b000;
      tick();
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL laf_exits step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    parity_done = 1'b1;
    tick();
    checks++;
    if (obs() !== V_DA) begin
      errors++;
      $display("FAIL laf_parity_done: got %b want %b", obs(), V_DA);
    end
    idle_inputs();
  endtask

  task automatic test_wait_till_empty();
    // Also covers pkt_valid falling during LFD: LD then LP.
    logic [8:0] exp_v [7] = '{V_WTE, V_WTE, V_LFD, V_LD, V_LP, V_CPE, V_DA};
    logic       pv    [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] em    [7] = '{3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    data_in = 2'd2;
    for (int i = 0; i < 7; i++) begin
      pkt_valid  = pv[i];
      fifo_empty = em[i];
      tick();
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL wte step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    checks++;
    if (dest_sel !== 3'b100) begin
      errors++;
      $display("FAIL wte_dest_sel: got %b want 100", dest_sel);
    end
    idle_inputs();
  endtask

  task automatic test_soft_reset();
    logic [8:0] exp_v [4] = '{V_LFD, V_LD, V_LD, V_DA};
    logic [2:0] sr    [4] = '{3'b000, 3'b000, 3'b100, 3'b010};
    data_in    = 2'd1;
    fifo_empty = 3'b010;
    pkt_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      soft_reset = sr[i];
      tick();
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("FAIL soft_reset step %0d: got %b want %b", i, obs(), exp_v[i]);
      end
    end
    idle_inputs();
    checks++;
    if (dest_sel !== 3'b010) begin
      errors++;
      $display("FAIL soft_reset_dest_sel: got %b want 010", dest_sel);
    end
  endtask

  task automatic test_drop();
    data_in   = 2'd3;
    pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs() !== V_DROP) begin
        errors++;
        $display("FAIL drop step %0d: got %b want %b", i, obs(), V_DROP);
      end
    end
    pkt_valid = 1'b0;
    tick();
    checks++;
    if (obs() !== V_DA || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_first: got %b count %0d want %b count 1", obs(), drop_count, V_DA);
    end
    for (int k = 2; k <= 300; k++) begin
      pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
      tick();
      if (k == 2 || k == 254 || k == 255) begin
        checks++;
        if (drop_count !== CNT_W'(k)) begin
          errors++;
          $display("FAIL drop_count after %0d: got %0d want %0d", k, drop_count, k);
        end
      end
    end
    checks++;
    if (drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d want 255", drop_count);
    end
    idle_inputs();
  endtask

  task automatic test_full_range_n4();
    // N == 2**ADDR_W: address 3 is a real channel, never a drop.
    idle_inputs();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    data_in   = 2'd3;
    pkt_valid = 1'b1;
    tick();
    checks++;
    if (lfd_state4 !== 1'b1 || drop_state4 !== 1'b0 || dest_sel4 !== 4'b1000) begin
      errors++;
      $display("FAIL n4_header: lfd %b drop %b dest %b want 1 0 1000",
               lfd_state4, drop_state4, dest_sel4);
    end
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (detect_add4 !== 1'b1 || drop_count4 !== 8'd0) begin
      errors++;
      $display("FAIL n4_end: detect_add %b count %0d want 1 0", detect_add4, drop_count4);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    data_in    = 2'd0;
    fifo_empty = 3'b001;
    pkt_valid  = 1'b1;
    tick();
    tick();
    fifo_full = 3'b001;
    tick();
    checks++;
    if (obs() !== V_FFS) begin
      errors++;
      $display("FAIL mid_reset_setup: got %b want %b", obs(), V_FFS);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs() !== V_DA || dest_sel !== 3'b000 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b dest %b count %0d want %b 000 0",
               obs(), dest_sel, drop_count, V_DA);
    end
    idle_inputs();
  endtask

  assign fifo_full4   = 4'b0000;
  assign fifo_empty4  = 4'b1111;
  assign soft_reset4  = 4'b0000;

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_packet();
    test_full_stall();
    test_laf_exits();
    test_wait_till_empty();
    test_soft_reset();
    test_drop();
    test_full_range_n4();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
